// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer and decoder side:
// codeword layout, symbol codes, unit multipliers and FSM states.
package morse_pkg;

   localparam int CW_WIDTH  = 20;
   localparam int SYM_COUNT = 10;

   localparam logic [1:0] SYM_END    = 2'b00;
   localparam logic [1:0] SYM_DOT    = 2'b01;
   localparam logic [1:0] SYM_DASH   = 2'b10;
   localparam logic [1:0] SYM_WSPACE = 2'b11;

   localparam logic [2:0] DOT_U        = 3'd1;
   localparam logic [2:0] DASH_U       = 3'd3;
   localparam logic [2:0] EGAP_U       = 3'd1;
   localparam logic [2:0] LGAP_EXTRA_U = 3'd2;
   localparam logic [2:0] WSPACE_U     = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ON,
      EGAP,
      LGAP,
      WSPACE
   } state_t;

   function automatic state_t sym_state(input logic [1:0] sym);
      state_t st;
      unique case (sym)
         SYM_DOT,
         SYM_DASH:   st = ON;
         SYM_WSPACE: st = WSPACE;
         default:    st = IDLE;
      endcase
      return st;
   endfunction

   function automatic logic [2:0] sym_units(input logic [1:0] sym);
      logic [2:0] n;
      unique case (sym)
         SYM_DOT:    n = DOT_U;
         SYM_DASH:   n = DASH_U;
         SYM_WSPACE: n = WSPACE_U;
         default:    n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Down-counter measuring whole Morse units; done pulses for one
// cycle on the last cycle of the loaded interval.
module morse_unit_timer #(
   parameter int UNIT_CYCLES = 1_200_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       load,
   input  logic [2:0] units,
   output logic       done
);

   localparam int W = $clog2(7 * UNIT_CYCLES + 1);

   logic [W-1:0] count;
   logic         run;

   assign done = run && (count == '0);

   // A load on the done edge restarts cleanly for chained phases
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count <= '0;
         run   <= 1'b0;
      end else if (load) begin
         count <= W'(int'(units) * UNIT_CYCLES - 1);
         run   <= 1'b1;
      end else if (done) begin
         run   <= 1'b0;
      end else if (run) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/morse_keyer.sv
// Fetches packed Morse codewords from the buffer and serializes
// them into an on/off key with standard unit timing.
module morse_keyer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 1_200_000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [CW_WIDTH-1:0] i_r_data,
   input  logic                i_avail,
   input  logic                i_enable,
   output logic                o_r_next,
   output logic                o_key,
   output logic                o_busy
);

   state_t              state;
   state_t              state_nxt;
   logic [CW_WIDTH-1:0] shreg;
   logic [3:0]          sym_cnt;
   logic                fetch;
   logic                advance;
   logic                tmr_load;
   logic [2:0]          tmr_units;
   logic                tmr_done;
   logic [1:0]          top_sym;
   logic [1:0]          next_sym;
   logic                last_sym;

   assign top_sym  = shreg[CW_WIDTH-1 -: 2];
   assign next_sym = shreg[CW_WIDTH-3 -: 2];
   assign last_sym = (sym_cnt == 4'(SYM_COUNT - 1));

   morse_unit_timer #(
      .UNIT_CYCLES(UNIT_CYCLES)
   ) u_timer (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .load (tmr_load),
      .units(tmr_units),
      .done (tmr_done)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fetch     = 1'b0;
      advance   = 1'b0;
      tmr_load  = 1'b0;
      tmr_units = DOT_U;
      unique case (state)
         IDLE: begin
            if (i_avail && i_enable) begin
               state_nxt = LOAD;
               fetch     = 1'b1;
            end
         end
         LOAD: begin
            state_nxt = sym_state(top_sym);
            tmr_load  = (top_sym != SYM_END);
            tmr_units = sym_units(top_sym);
         end
         ON: begin
            if (tmr_done) begin
               state_nxt = EGAP;
               tmr_load  = 1'b1;
               tmr_units = EGAP_U;
            end
         end
         EGAP: begin
            if (tmr_done) begin
               advance  = 1'b1;
               tmr_load = 1'b1;
               if (next_sym == SYM_END || last_sym) begin
                  state_nxt = LGAP;
                  tmr_units = LGAP_EXTRA_U;
               end else begin
                  state_nxt = sym_state(next_sym);
                  tmr_units = sym_units(next_sym);
               end
            end
         end
         LGAP,
         WSPACE: begin
            if (tmr_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_key    = (state == ON);
      o_r_next = (state == LOAD);
      o_busy   = (state != IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         shreg   <= '0;
         sym_cnt <= '0;
      end else if (fetch) begin
         shreg   <= i_r_data;
         sym_cnt <= '0;
      end else if (advance) begin
         shreg   <= {shreg[CW_WIDTH-3:0], SYM_END};
         sym_cnt <= sym_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer with UNIT_CYCLES = 4.
module tb_morse_keyer;

   localparam int U = 4;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        avail  = 1'b0;
   logic        enable = 1'b0;
   logic [19:0] r_data = '0;
   logic        r_next;
   logic        key;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   bit exp_q[$];

   typedef struct {
      logic [19:0] word;
      int          on_cyc;
      int          busy_cyc;
   } vec_t;

   vec_t vecs[6];

   morse_keyer #(
      .UNIT_CYCLES(U)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_r_data(r_data),
      .i_avail (avail),
      .i_enable(enable),
      .o_r_next(r_next),
      .o_key   (key),
      .o_busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   // Expected key level per cycle after the fetch cycle, from Morse rules
   function automatic void model(input logic [19:0] w);
      logic [1:0] sym;
      exp_q = {};
      for (int s = 0; s < 10; s++) begin
         sym = 2'(w >> (18 - 2 * s));
         if (sym == 2'b00) begin
            if (s > 0) repeat (2 * U) exp_q.push_back(1'b0);
            break;
         end
         if (sym == 2'b11) begin
            repeat (7 * U) exp_q.push_back(1'b0);
            break;
         end
         repeat ((sym == 2'b01 ? 1 : 3) * U) exp_q.push_back(1'b1);
         repeat (U) exp_q.push_back(1'b0);
         if (s == 9) repeat (2 * U) exp_q.push_back(1'b0);
      end
   endfunction

   // Called at a negedge with the DUT idle
   task automatic run_word(input logic [19:0] w, input string nm,
                           output int on_c, output int busy_c);
      int pulses;
      model(w);
      on_c   = 0;
      busy_c = 0;
      pulses = 0;
      r_data = w;
      avail  = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      chk({nm, ".load"}, 0, {key, busy, r_next}, 3'b011);
      avail = 1'b0;
      busy_c += busy;
      pulses += r_next;
      foreach (exp_q[i]) begin
         @(negedge clk);
         chk({nm, ".cyc"}, i + 1, {key, busy, r_next}, {exp_q[i], 2'b10});
         on_c   += key;
         busy_c += busy;
         pulses += r_next;
      end
      @(negedge clk);
      chk({nm, ".idle"}, 0, {key, busy, r_next}, 3'b000);
      busy_c += busy;
      pulses += r_next;
      chk({nm, ".pulses"}, 0, pulses, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int on_c, bc, pulses, bsy, cyc;
      logic [19:0] w;
      logic [1:0]  sym;
      int          k;

      vecs[0] = '{20'h60000, 16, 33};
      vecs[1] = '{20'h00000, 0, 1};
      vecs[2] = '{20'hAAAAA, 120, 169};
      vecs[3] = '{20'hC0000, 0, 29};
      vecs[4] = '{20'h00001, 0, 1};
      vecs[5] = '{20'h5C000, 8, 45};

      repeat (2) @(negedge clk);
      chk("reset", 0, {key, busy, r_next}, 3'b000);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset", 0, {key, busy, r_next}, 3'b000);

      foreach (vecs[i]) begin
         run_word(vecs[i].word, $sformatf("vec%0d", i), on_c, bc);
         chk("vec.on", i, on_c, vecs[i].on_cyc);
         chk("vec.busy", i, bc, vecs[i].busy_cyc);
      end

      // Enable low blocks fetching
      r_data = '0;
      enable = 1'b0;
      avail  = 1'b1;
      pulses = 0;
      bsy    = 0;
      repeat (100) begin
         @(negedge clk);
         pulses += r_next;
         bsy    += busy;
      end
      chk("en0.pulses", 0, pulses, 0);
      chk("en0.busy", 0, bsy, 0);
      enable = 1'b1;
      @(negedge clk);
      chk("en1.fetch", 0, r_next, 1);
      avail = 1'b0;
      @(negedge clk);
      chk("en1.idle", 0, busy, 0);

      // Dropping enable mid-word finishes it and fetches nothing more
      r_data = 20'h60000;
      avail  = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      chk("drop.fetch", 0, r_next, 1);
      enable = 1'b0;
      on_c = 0;
      cyc  = 0;
      while (busy && cyc < 200) begin
         @(negedge clk);
         on_c += key;
         cyc++;
      end
      chk("drop.done", 0, busy, 0);
      chk("drop.on", 0, on_c, 16);
      chk("drop.len", 0, cyc, 33);
      pulses = 0;
      bsy    = 0;
      repeat (40) begin
         @(negedge clk);
         pulses += r_next;
         bsy    += busy;
      end
      chk("drop.pulses", 0, pulses, 0);
      chk("drop.busy", 0, bsy, 0);
      avail  = 1'b0;
      enable = 1'b1;

      // Back-to-back word spaces: refetch 1 + 28 + 1 cycles later
      r_data = 20'hC0000;
      avail  = 1'b1;
      @(negedge clk);
      chk("b2b.fetch1", 0, r_next, 1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc <= 28) chk("b2b.low", cyc, {key, busy}, 2'b01);
      end while (!r_next && cyc < 100);
      chk("b2b.gap", 0, cyc, 30);
      avail = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b.idle", 0, busy, 0);

      // Reset during the third cycle of a dash
      r_data = 20'h80000;
      avail  = 1'b1;
      @(negedge clk);
      chk("rst.fetch", 0, r_next, 1);
      avail = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.pre", 0, key, 1);
      rst = 1'b1;
      #1;
      chk("rst.key", 0, {key, busy, r_next}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      bsy    = 0;
      repeat (20) begin
         @(negedge clk);
         pulses += r_next;
         bsy    += busy;
      end
      chk("rst.pulses", 0, pulses, 0);
      chk("rst.busy", 0, bsy, 0);
      r_data = '0;
      avail  = 1'b1;
      @(negedge clk);
      chk("rst.refetch", 0, r_next, 1);
      avail = 1'b0;
      @(negedge clk);
      chk("rst.idle", 0, busy, 0);

      // Random codewords against the reference model
      for (int t = 0; t < 25; t++) begin
         if (t % 5 == 4) begin
            w = 20'($urandom);
         end else begin
            w = '0;
            k = $urandom_range(0, 10);
            for (int s = 0; s < k; s++) begin
               if ($urandom_range(0, 9) == 0) sym = 2'b11;
               else sym = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
               w |= 20'(sym) << (18 - 2 * s);
            end
         end
         run_word(w, $sformatf("rnd%0d", t), on_c, bc);
         chk("rnd.busy", t, bc, exp_q.size() + 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
